// File: rtl/mc_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : mc_burst_seq
// Description : Burst address sequencer, linear or wrapping (2/4/8 beats),
//               with valid/ready backpressure, abort and done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_burst_seq #(
  parameter int AW = 32,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] burst_len,
  input  logic          wrap,
  input  logic          abort,
  output logic [AW-1:0] addr,
  output logic          addr_vld,
  input  logic          addr_rdy,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam int c_HW = AW / 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_cnt;
  logic [2:0]      r_wmask;
  logic            r_lo_max;
  logic            r_done;

  logic            w_last;
  logic            w_load;
  logic            w_adv;
  logic            w_done_nxt;
  logic [2:0]      w_wmask_in;
  logic [c_HW-1:0] w_lo;
  logic [c_HW-1:0] w_hi;
  logic [c_HW-1:0] w_lo_inc;
  logic [c_HW-1:0] w_lo_nxt;
  logic [c_HW-1:0] w_hi_nxt;
  logic [c_HW-1:0] w_mask_lo;

  assign w_last = (r_state == S_RUN) && (r_cnt == r_len);

  // Wrapping only for power-of-two bursts of 2, 4 or 8 beats; otherwise linear.
  always_comb begin
    w_wmask_in = 3'b000;
    if (wrap) begin
      if (burst_len == LW'(1))      w_wmask_in = 3'b001;
      else if (burst_len == LW'(3)) w_wmask_in = 3'b011;
      else if (burst_len == LW'(7)) w_wmask_in = 3'b111;
    end
  end

  // Low half increments now; high half uses the carry registered with the
  // current address, so neither half sees a full AW-bit carry chain.
  assign w_lo      = r_addr[c_HW-1:0];
  assign w_hi      = r_addr[AW-1:c_HW];
  assign w_lo_inc  = w_lo + c_HW'(1);
  assign w_mask_lo = c_HW'(r_wmask);
  assign w_lo_nxt  = (r_wmask == 3'b000) ? w_lo_inc
                                         : ((w_lo & ~w_mask_lo) | (w_lo_inc & w_mask_lo));
  assign w_hi_nxt  = ((r_wmask == 3'b000) && r_lo_max) ? (w_hi + c_HW'(1)) : w_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (addr_rdy && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (addr_rdy) begin
          w_adv = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_wmask  <= '0;
      r_lo_max <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_addr   <= base_addr;
        r_len    <= burst_len;
        r_cnt    <= '0;
        r_wmask  <= w_wmask_in;
        r_lo_max <= &base_addr[c_HW-1:0];
      end else if (w_adv) begin
        r_addr   <= {w_hi_nxt, w_lo_nxt};
        r_cnt    <= r_cnt + LW'(1);
        r_lo_max <= &w_lo_nxt;
      end
    end
  end

  assign addr     = r_addr;
  assign addr_vld = (r_state == S_RUN);
  assign busy     = (r_state == S_RUN);
  assign last     = w_last;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mc_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_burst_seq
// Description : Directed self-checking bench for mc_burst_seq (AW=32, LW=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_burst_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [2:0]  burst_len;
  logic        wrap;
  logic        abort;
  logic [31:0] addr;
  logic        addr_vld;
  logic        addr_rdy;
  logic        last;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  mc_burst_seq #(.AW(32), .LW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .wrap      (wrap),
    .abort     (abort),
    .addr      (addr),
    .addr_vld  (addr_vld),
    .addr_rdy  (addr_rdy),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [31:0] b, input logic [2:0] l, input logic w);
    base_addr = b;
    burst_len = l;
    wrap      = w;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0;
    wrap = 1'b0; abort = 1'b0; addr_rdy = 1'b1;
    #1;
    n_vec++;
    if (addr !== 32'h0 || addr_vld !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: addr=%h vld=%b last=%b busy=%b done=%b, want all 0", addr, addr_vld, last, busy, done);
    end
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_linear();
    logic [31:0] ex [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    kick(32'h100, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (addr !== ex[i] || addr_vld !== 1'b1 || busy !== 1'b1 || last !== (i == 3)) begin
        n_err++;
        $display("FAIL linear beat %0d: addr=%h vld=%b last=%b, want addr=%h vld=1 last=%b", i, addr, addr_vld, last, ex[i], i == 3);
      end
      cyc();
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || addr_vld !== 1'b0) begin
      n_err++;
      $display("FAIL linear done: done=%b busy=%b vld=%b, want 1 0 0", done, busy, addr_vld);
    end
    cyc();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL linear done width: done=%b, want 0", done);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ex [8] = '{32'h10E, 32'h10F, 32'h108, 32'h109, 32'h10A, 32'h10B, 32'h10C, 32'h10D};
    logic [31:0] ex3 [3] = '{32'h1E, 32'h1F, 32'h20};
    kick(32'h10E, 3'd7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (addr !== ex[i] || addr_vld !== 1'b1 || last !== (i == 7)) begin
        n_err++;
        $display("FAIL wrap8 beat %0d: addr=%h last=%b, want addr=%h last=%b", i, addr, last, ex[i], i == 7);
      end
      cyc();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap8 done: done=%b, want 1", done);
    end
    cyc();
    // Three beats with wrap requested is not a power of two: runs linear.
    kick(32'h1E, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (addr !== ex3[i] || last !== (i == 2)) begin
        n_err++;
        $display("FAIL wrap3_linear beat %0d: addr=%h last=%b, want addr=%h last=%b", i, addr, last, ex3[i], i == 2);
      end
      cyc();
    end
    cyc();
  endtask

  task automatic test_carry_back_to_back();
    logic [31:0] exa [2] = '{32'h0000_FFFF, 32'h0001_0000};
    logic [31:0] exb [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    kick(32'h0000_FFFF, 3'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (addr !== exa[i] || last !== (i == 1)) begin
        n_err++;
        $display("FAIL carry beat %0d: addr=%h last=%b, want addr=%h last=%b", i, addr, last, exa[i], i == 1);
      end
      cyc();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL carry done: done=%b, want 1", done);
    end
    // Start presented while done is high must be accepted.
    kick(32'hFFFF_FFFF, 3'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (addr !== exb[i] || addr_vld !== 1'b1 || last !== (i == 1)) begin
        n_err++;
        $display("FAIL b2b rollover beat %0d: addr=%h vld=%b last=%b, want addr=%h vld=1 last=%b", i, addr, addr_vld, last, exb[i], i == 1);
      end
      cyc();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b done: done=%b, want 1", done);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic        rdy_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ex      [5] = '{32'h20, 32'h21, 32'h21, 32'h21, 32'h22};
    logic        exl     [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          dn = 0;
    kick(32'h20, 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      addr_rdy = rdy_seq[i];
      // Mid-burst start and new parameters must be ignored.
      if (i == 1) begin
        start = 1'b1; base_addr = 32'h999; burst_len = 3'd0;
      end
      n_vec++;
      if (addr !== ex[i] || addr_vld !== 1'b1 || last !== exl[i]) begin
        n_err++;
        $display("FAIL backpressure cycle %0d: addr=%h vld=%b last=%b, want addr=%h vld=1 last=%b", i, addr, addr_vld, last, ex[i], exl[i]);
      end
      cyc();
      start = 1'b0;
    end
    addr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) dn++;
      cyc();
    end
    n_vec++;
    if (dn != 1) begin
      n_err++;
      $display("FAIL backpressure done count: got %0d, want 1", dn);
    end
  endtask

  task automatic test_abort();
    kick(32'h40, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (addr !== 32'h40 + i || addr_vld !== 1'b1) begin
        n_err++;
        $display("FAIL abort beat %0d: addr=%h vld=%b, want addr=%h vld=1", i, addr, addr_vld, 32'h40 + i);
      end
      if (i == 2) abort = 1'b1;
      cyc();
    end
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || addr_vld !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort exit: busy=%b vld=%b done=%b, want 0 0 0", busy, addr_vld, done);
    end
    cyc();
    n_vec++;
    if (done !== 1'b0 || addr_vld !== 1'b0) begin
      n_err++;
      $display("FAIL abort after: done=%b vld=%b, want 0 0", done, addr_vld);
    end
  endtask

  task automatic test_reset_mid();
    kick(32'h300, 3'd7, 1'b0);
    cyc(); cyc();
    n_vec++;
    if (addr !== 32'h302 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid pre: addr=%h busy=%b, want 302 1", addr, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (addr !== 32'h0 || addr_vld !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid async: addr=%h vld=%b last=%b busy=%b done=%b, want all 0", addr, addr_vld, last, busy, done);
    end
    #1 rst = 1'b0;
    abort = 1'b1;
    kick(32'h80, 3'd0, 1'b0);
    abort = 1'b0;
    n_vec++;
    if (addr !== 32'h80 || addr_vld !== 1'b1 || last !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid single: addr=%h vld=%b last=%b done=%b, want 80 1 1 0", addr, addr_vld, last, done);
    end
    cyc();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid done: done=%b busy=%b, want 1 0", done, busy);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_linear();
    test_wrap();
    test_carry_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
